// File: rtl/prim_filter_cnt_pkg.sv
// prim_filter_cnt_pkg
//   Shared constants and helpers for the counter-based glitch filter.
//   - MaxCycles    : largest supported stability window
//   - cnt_width()  : counter width needed to hold 0..Cycles
//   - cycles_legal(): elaboration-time range check for the Cycles parameter
package prim_filter_cnt_pkg;

    localparam int MaxCycles = 65535;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    function automatic bit cycles_legal(input int cycles);
        return (cycles >= 1) && (cycles <= MaxCycles);
    endfunction

endpackage

// File: rtl/prim_filter_cnt_bit.sv
// prim_filter_cnt_bit
//   Single-channel counter-based glitch filter. The output only follows the
//   input once the input has been sampled equal for Cycles consecutive
//   enabled samples. Registered one-cycle rise/fall pulses accompany each
//   change of the filtered value.
// Ports:
//   clk_i    : clock, all state on rising edge
//   rst_i    : synchronous active-high reset, overrides en_i
//   en_i     : sample enable; low freezes the filter state
//   filter_i : synchronized, unfiltered input bit
//   filter_o : filtered value (registered)
//   rise_o   : one-cycle pulse when filter_o goes 0->1
//   fall_o   : one-cycle pulse when filter_o goes 1->0
module prim_filter_cnt_bit
    import prim_filter_cnt_pkg::*;
#(
    parameter int   Cycles     = 4,
    parameter logic ResetValue = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic filter_i,
    output logic filter_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int                CntW   = cnt_width(Cycles);
    localparam logic [CntW-1:0]   CntMax = CntW'(Cycles);

    logic            r_in_q;
    logic            r_out_q;
    logic            r_rise_q;
    logic            r_fall_q;
    logic [CntW-1:0] r_cnt;

    logic            w_changed;
    logic [CntW-1:0] w_cnt_next;
    logic            w_settle;

    always_comb begin
        w_changed  = (filter_i != r_in_q);
        // A new value counts as its own first sample; otherwise saturate.
        if (w_changed) begin
            w_cnt_next = CntW'(1);
        end else if (r_cnt == CntMax) begin
            w_cnt_next = CntMax;
        end else begin
            w_cnt_next = r_cnt + CntW'(1);
        end
        // Commit when the run reaches the window and carries a new value.
        w_settle = (w_cnt_next == CntMax) && (filter_i != r_out_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_in_q   <= ResetValue;
            r_out_q  <= ResetValue;
            r_cnt    <= CntMax;
            r_rise_q <= 1'b0;
            r_fall_q <= 1'b0;
        end else if (en_i) begin
            r_in_q <= filter_i;
            r_cnt  <= w_cnt_next;
            if (w_settle) begin
                r_out_q  <= filter_i;
                r_rise_q <= filter_i;
                r_fall_q <= ~filter_i;
            end else begin
                r_rise_q <= 1'b0;
                r_fall_q <= 1'b0;
            end
        end else begin
            // Frozen: keep progress, but never stretch a pulse.
            r_rise_q <= 1'b0;
            r_fall_q <= 1'b0;
        end
    end

    assign filter_o = r_out_q;
    assign rise_o   = r_rise_q;
    assign fall_o   = r_fall_q;

endmodule

// File: rtl/prim_filter_cnt.sv
// prim_filter_cnt
//   Width independent counter-based glitch filters, placed directly after an
//   input synchronizer. Adds no metastability protection of its own.
// Parameters:
//   Width      : number of channels
//   Cycles     : consecutive equal samples required (1..65535)
//   ResetValue : per-bit reset value of filter_o and the internal sample
// Ports:
//   clk_i, rst_i (sync, active high), en_i (sample enable)
//   filter_i : unfiltered inputs
//   filter_o : filtered outputs (registered)
//   rise_o   : per-bit one-cycle 0->1 pulse of filter_o
//   fall_o   : per-bit one-cycle 1->0 pulse of filter_o
module prim_filter_cnt
    import prim_filter_cnt_pkg::*;
#(
    parameter int               Width      = 1,
    parameter int               Cycles     = 4,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [Width-1:0] filter_i,
    output logic [Width-1:0] filter_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o
);

    localparam int CntW = cnt_width(Cycles);

    if (!cycles_legal(Cycles) || (CntW < 1)) begin : g_bad_cycles
        $error("prim_filter_cnt: Cycles must be in 1..65535");
    end

    for (genvar gi = 0; gi < Width; gi++) begin : g_bit
        prim_filter_cnt_bit #(
            .Cycles     (Cycles),
            .ResetValue (ResetValue[gi])
        ) u_bit (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .en_i     (en_i),
            .filter_i (filter_i[gi]),
            .filter_o (filter_o[gi]),
            .rise_o   (rise_o[gi]),
            .fall_o   (fall_o[gi])
        );
    end

endmodule

// File: tb/tb_prim_filter_cnt.sv
module tb_prim_filter_cnt;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] fin;

    logic [1:0] fo [3];
    logic [1:0] ro [3];
    logic [1:0] fa [3];

    int errors = 0;
    int checks = 0;
    int ncyc   = 0;

    // Instance 0: Cycles=4 reset 00; 1: Cycles=4 reset 10; 2: Cycles=1 reset 00
    int         cyc [3] = '{4, 4, 1};
    logic [1:0] rv  [3] = '{2'b00, 2'b10, 2'b00};

    // Reference model: last four enabled samples per bit (index 0 newest).
    bit         hist  [3][2][4];
    logic [1:0] m_out [3];
    logic [1:0] m_rise[3];
    logic [1:0] m_fall[3];

    always #5 clk = ~clk;

    prim_filter_cnt #(.Width(2), .Cycles(4), .ResetValue(2'b00)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .en_i(en), .filter_i(fin),
        .filter_o(fo[0]), .rise_o(ro[0]), .fall_o(fa[0])
    );

    prim_filter_cnt #(.Width(2), .Cycles(4), .ResetValue(2'b10)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .en_i(en), .filter_i(fin),
        .filter_o(fo[1]), .rise_o(ro[1]), .fall_o(fa[1])
    );

    prim_filter_cnt #(.Width(2), .Cycles(1), .ResetValue(2'b00)) u_dut_c (
        .clk_i(clk), .rst_i(rst), .en_i(en), .filter_i(fin),
        .filter_o(fo[2]), .rise_o(ro[2]), .fall_o(fa[2])
    );

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Output follows once the most recent Cycles enabled samples all agree
    // on a value different from the current output; reset counts as a full
    // window of ResetValue samples.
    task automatic model_edge(input logic r, input logic e, input logic [1:0] f);
        bit all_eq;
        for (int i = 0; i < 3; i++) begin
            for (int b = 0; b < 2; b++) begin
                if (r) begin
                    for (int k = 0; k < 4; k++) hist[i][b][k] = rv[i][b];
                    m_out[i][b]  = rv[i][b];
                    m_rise[i][b] = 1'b0;
                    m_fall[i][b] = 1'b0;
                end else if (!e) begin
                    m_rise[i][b] = 1'b0;
                    m_fall[i][b] = 1'b0;
                end else begin
                    for (int k = 3; k > 0; k--) hist[i][b][k] = hist[i][b][k-1];
                    hist[i][b][0] = f[b];
                    all_eq = 1'b1;
                    for (int k = 0; k < cyc[i]; k++)
                        if (hist[i][b][k] != f[b]) all_eq = 1'b0;
                    if (all_eq && (f[b] != m_out[i][b])) begin
                        m_out[i][b]  = f[b];
                        m_rise[i][b] = f[b];
                        m_fall[i][b] = ~f[b];
                    end else begin
                        m_rise[i][b] = 1'b0;
                        m_fall[i][b] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic [1:0] f);
        rst = r;
        en  = e;
        fin = f;
        @(posedge clk);
        model_edge(r, e, f);
        #1;
        ncyc++;
        $display("cyc %0d rst=%b en=%b in=%b out=%b/%b/%b rise=%b/%b/%b fall=%b/%b/%b",
                 ncyc, r, e, f, fo[0], fo[1], fo[2], ro[0], ro[1], ro[2],
                 fa[0], fa[1], fa[2]);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("filter_o[%0d]", i), fo[i], m_out[i]);
            chk($sformatf("rise_o[%0d]", i), ro[i], m_rise[i]);
            chk($sformatf("fall_o[%0d]", i), fa[i], m_fall[i]);
        end
    endtask

    initial begin
        logic [1:0] f_rand;
        logic       r_rand;
        logic       e_rand;

        rst = 1'b1;
        en  = 1'b0;
        fin = 2'b00;

        // Reset state
        cycle(1'b1, 1'b0, 2'b00);
        cycle(1'b1, 1'b1, 2'b00);
        chk("reset_b_value", fo[1], 2'b10);

        // Step 00 -> 01 with Cycles=4
        cycle(1'b0, 1'b1, 2'b01);
        cycle(1'b0, 1'b1, 2'b01);
        cycle(1'b0, 1'b1, 2'b01);
        chk("step_hold_e2", fo[0], 2'b00);
        cycle(1'b0, 1'b1, 2'b01);
        chk("step_out_e3", fo[0], 2'b01);
        chk("step_rise_e3", ro[0], 2'b01);
        cycle(1'b0, 1'b1, 2'b01);
        chk("step_rise_gone", ro[0], 2'b00);
        cycle(1'b0, 1'b1, 2'b01);

        // Back to steady 00, then a 3-sample glitch
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, 2'b00);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 2'b01);
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 1'b1, 2'b00);
            chk("glitch_out", fo[0], 2'b00);
            chk("glitch_rise", ro[0], 2'b00);
        end

        // Enable freeze mid-transition
        cycle(1'b0, 1'b1, 2'b01);
        cycle(1'b0, 1'b1, 2'b01);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b0, 2'b01);
            chk("freeze_out", fo[0], 2'b00);
        end
        cycle(1'b0, 1'b1, 2'b01);
        chk("freeze_third", fo[0], 2'b00);
        cycle(1'b0, 1'b1, 2'b01);
        chk("freeze_done", fo[0], 2'b01);
        chk("freeze_rise", ro[0], 2'b01);

        // Reach 11, then drop bit1 only
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 2'b11);
        chk("both_high", fo[0], 2'b11);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 2'b01);
        chk("fall_hold", fo[0], 2'b11);
        cycle(1'b0, 1'b1, 2'b01);
        chk("fall_out", fo[0], 2'b01);
        chk("fall_pulse", fa[0], 2'b10);
        cycle(1'b0, 1'b1, 2'b01);

        // Reset during a pending transition
        cycle(1'b0, 1'b1, 2'b10);
        cycle(1'b0, 1'b1, 2'b10);
        cycle(1'b1, 1'b1, 2'b10);
        chk("rst_mid_b_out", fo[1], 2'b10);
        chk("rst_mid_b_rise", ro[1], 2'b00);
        chk("rst_mid_b_fall", fa[1], 2'b00);
        chk("rst_mid_a_out", fo[0], 2'b00);

        // Random phase
        f_rand = 2'b00;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 2) == 0) f_rand = 2'($urandom_range(0, 3));
            r_rand = ($urandom_range(0, 59) == 0);
            e_rand = ($urandom_range(0, 4) != 0);
            cycle(r_rand, e_rand, f_rand);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
